// File: rtl/clk_time_ctrl_if.sv
// Front-panel bundle: raw push-buttons into the controller, counter-control pulses out.
interface clk_time_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_clr;
    logic       btn_fmt;
    logic       sec_tick;
    logic       inc_min;
    logic       inc_hr;
    logic       rst_counters;
    logic       time_format;
    logic [1:0] set_mode;
    logic       blink;

    modport master (
        output btn_mode, btn_inc, btn_clr, btn_fmt,
        input  sec_tick, inc_min, inc_hr, rst_counters, time_format, set_mode, blink
    );

    modport slave (
        input  btn_mode, btn_inc, btn_clr, btn_fmt,
        output sec_tick, inc_min, inc_hr, rst_counters, time_format, set_mode, blink
    );
endinterface

// File: rtl/clk_time_ctrl.sv
// Front-panel controller: button sync/debounce, RUN/SET_HR/SET_MIN sequencing, 1 Hz tick, blink.
// Optional inc auto-repeat in set states is enabled by defining TIME_CTRL_AUTO_REPEAT_EN.
module clk_time_ctrl #(
    parameter int unsigned CLK_HZ        = 1000,
    parameter int unsigned DEBOUNCE_MS   = 20
`ifdef TIME_CTRL_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DLY_MS = 500,
    parameter int unsigned REPEAT_PER_MS = 200
`endif
) (
    input  logic           CLK,
    input  logic           rst_n,
    clk_time_ctrl_if.slave bus
);

    localparam int unsigned DB_CYC    = DEBOUNCE_MS * CLK_HZ / 1000;
    localparam int unsigned DB_W      = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int unsigned PRE_W     = $clog2(CLK_HZ);
    localparam int unsigned BLINK_CYC = CLK_HZ / 4;
    localparam int unsigned BL_W      = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam int unsigned NBTN      = 4;
    localparam int unsigned B_MODE    = 0;
    localparam int unsigned B_INC     = 1;
    localparam int unsigned B_CLR     = 2;
    localparam int unsigned B_FMT     = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    logic [NBTN-1:0]           btn_raw;
    logic [NBTN-1:0]           sync1_q, sync2_q;
    logic [NBTN-1:0]           db_lvl_q, db_prev_q, press_q;
    logic [NBTN-1:0][DB_W-1:0] db_cnt_q;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [BL_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;
    logic             fmt_q, fmt_d;
    logic             sec_tick_q, sec_tick_d;
    logic             inc_min_q, inc_min_d;
    logic             inc_hr_q, inc_hr_d;
    logic             rst_cnt_q, rst_cnt_d;
    logic             clr_ev, mode_ev, inc_ev;

    assign btn_raw = {bus.btn_fmt, bus.btn_clr, bus.btn_inc, bus.btn_mode};

    // Sync, debounce (counter cleared whenever the synced level matches the accepted level), rising-edge pulse
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_lvl_q  <= '0;
            db_prev_q <= '0;
            press_q   <= '0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync2_q[i] == db_lvl_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DB_CYC - 1)) begin
                    db_lvl_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
            db_prev_q <= db_lvl_q;
            press_q   <= db_lvl_q & ~db_prev_q;
        end
    end

    assign clr_ev  = press_q[B_CLR];
    assign mode_ev = press_q[B_MODE];

`ifdef TIME_CTRL_AUTO_REPEAT_EN
    localparam int unsigned REP_DLY_CYC = REPEAT_DLY_MS * CLK_HZ / 1000;
    localparam int unsigned REP_PER_CYC = REPEAT_PER_MS * CLK_HZ / 1000;
    localparam int unsigned REP_W       = $clog2(REP_DLY_CYC);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_ev;

    // Hold counter: fires at the initial delay, then reloads so later fires are one period apart
    always_comb begin
        rep_cnt_d = '0;
        rep_ev    = 1'b0;
        if (state_q != ST_RUN && state_d == state_q && db_lvl_q[B_INC] && !press_q[B_INC]) begin
            if (rep_cnt_q == REP_W'(REP_DLY_CYC - 1)) begin
                rep_ev    = 1'b1;
                rep_cnt_d = REP_W'(REP_DLY_CYC - REP_PER_CYC);
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) rep_cnt_q <= '0;
        else        rep_cnt_q <= rep_cnt_d;
    end

    assign inc_ev = press_q[B_INC] | rep_ev;
`else
    assign inc_ev = press_q[B_INC];
`endif

    // Next state and next values of every registered output
    always_comb begin
        state_d     = state_q;
        fmt_d       = fmt_q;
        sec_tick_d  = 1'b0;
        inc_min_d   = 1'b0;
        inc_hr_d    = 1'b0;
        rst_cnt_d   = 1'b0;
        presc_d     = '0;
        blink_d     = 1'b0;
        blink_cnt_d = '0;

        if (press_q[B_FMT]) fmt_d = ~fmt_q;

        if (clr_ev) begin
            state_d   = ST_RUN;
            rst_cnt_d = 1'b1;
        end else if (mode_ev) begin
            case (state_q)
                ST_RUN:    state_d = ST_SET_HR;
                ST_SET_HR: state_d = ST_SET_MIN;
                default:   state_d = ST_RUN;
            endcase
        end else if (inc_ev) begin
            case (state_q)
                ST_SET_HR:  inc_hr_d  = 1'b1;
                ST_SET_MIN: inc_min_d = 1'b1;
                default:    ;
            endcase
        end

        // Count only when staying in RUN so the first tick after a set state lands CLK_HZ cycles later
        if (state_q == ST_RUN && state_d == ST_RUN && !clr_ev) begin
            if (presc_q == PRE_W'(CLK_HZ - 1)) begin
                sec_tick_d = 1'b1;
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end

        if (state_d != ST_RUN) begin
            if (state_q == ST_RUN) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BL_W'(BLINK_CYC - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            fmt_q       <= 1'b1;
            sec_tick_q  <= 1'b0;
            inc_min_q   <= 1'b0;
            inc_hr_q    <= 1'b0;
            rst_cnt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            fmt_q       <= fmt_d;
            sec_tick_q  <= sec_tick_d;
            inc_min_q   <= inc_min_d;
            inc_hr_q    <= inc_hr_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

    assign bus.sec_tick     = sec_tick_q;
    assign bus.inc_min      = inc_min_q;
    assign bus.inc_hr       = inc_hr_q;
    assign bus.rst_counters = rst_cnt_q;
    assign bus.time_format  = fmt_q;
    assign bus.set_mode     = state_q;
    assign bus.blink        = blink_q;

endmodule

// File: tb/tb_clk_time_ctrl.sv
// Directed bench for clk_time_ctrl at CLK_HZ=1000, DEBOUNCE_MS=2 (debounce N=2, press latency 6 cycles).
// Cycle index 0 is the first clock edge after reset release.
module tb_clk_time_ctrl;

    localparam int unsigned CLK_HZ      = 1000;
    localparam int unsigned DEBOUNCE_MS = 2;
    localparam int          LAT         = 6;

    logic CLK = 1'b0;
    logic rst_n;

    clk_time_ctrl_if bus ();

    clk_time_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) dut (
        .CLK  (CLK),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int edges;
    int n_tick = 0, n_inc_min = 0, n_inc_hr = 0, n_rst = 0, n_excl = 0;
    int tick_log[$];
    int inc_log[$];
    int mode_chg_idx = -1;
    int rst_idx = -1;
    logic [1:0] prev_mode = 2'b00;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Pulse monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (rst_n) begin
            if (bus.sec_tick)     begin n_tick++;    tick_log.push_back(edges - 1); end
            if (bus.inc_min)      begin n_inc_min++; inc_log.push_back(edges - 1);  end
            if (bus.inc_hr)       n_inc_hr++;
            if (bus.rst_counters) begin n_rst++;     rst_idx = edges - 1;           end
            if (int'(bus.sec_tick) + int'(bus.inc_min) + int'(bus.inc_hr) + int'(bus.rst_counters) > 1)
                n_excl++;
        end
        if (bus.set_mode != prev_mode) mode_chg_idx = edges - 1;
        prev_mode = bus.set_mode;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic int tick_at(input int i);
        return (i < tick_log.size()) ? tick_log[i] : -1;
    endfunction

    function automatic int inc_at(input int i);
        return (i < inc_log.size()) ? inc_log[i] : -1;
    endfunction

    // m = {fmt, clr, inc, mode}; 5-cycle press then 10 idle cycles; pidx = index of the driving negedge
    task automatic press(input logic [3:0] m, output int pidx);
        @(negedge CLK);
        pidx = edges - 1;
        {bus.btn_fmt, bus.btn_clr, bus.btn_inc, bus.btn_mode} = m;
        cycles(5);
        {bus.btn_fmt, bus.btn_clr, bus.btn_inc, bus.btn_mode} = 4'b0000;
        cycles(10);
    endtask

    task automatic glitch_mode();
        @(negedge CLK);
        bus.btn_mode = 1'b1;
        @(negedge CLK);
        bus.btn_mode = 1'b0;
        cycles(10);
    endtask

    int p, t0, i0, m0, r0, mc, wait_n;
    int offs[5] = '{0, 500, 700, 900, 1100};

    initial begin
        rst_n = 1'b0;
        {bus.btn_fmt, bus.btn_clr, bus.btn_inc, bus.btn_mode} = 4'b0000;
        cycles(3);
        check("rst_set_mode", 32'(bus.set_mode), 0);
        check("rst_time_format", 32'(bus.time_format), 1);
        check("rst_blink", 32'(bus.blink), 0);
        check("rst_pulses", 32'({bus.sec_tick, bus.inc_min, bus.inc_hr, bus.rst_counters}), 0);
        rst_n = 1'b1;

        // Idle: ticks at cycles 999, 1999, 2999 and nothing else
        cycles(3001);
        check("idle_tick_count", 32'(tick_log.size()), 3);
        check("idle_tick0", 32'(tick_at(0)), 999);
        check("idle_tick1", 32'(tick_at(1)), 1999);
        check("idle_tick2", 32'(tick_at(2)), 2999);
        check("idle_other_pulses", 32'(n_inc_min + n_inc_hr + n_rst), 0);

        glitch_mode();
        glitch_mode();
        check("glitch_set_mode", 32'(bus.set_mode), 0);

        // Clean press into SET_HR; blink starts high for CLK_HZ/4 cycles
        press(4'b0001, p);
        check("mode_latency", 32'(mode_chg_idx - p), 32'(LAT));
        check("sethr_set_mode", 32'(bus.set_mode), 1);
        check("sethr_blink_entry", 32'(bus.blink), 1);
        wait_n = (mode_chg_idx + 249) - (edges - 1);
        if (wait_n > 0) cycles(wait_n);
        check("blink_hold", 32'(bus.blink), 1);
        cycles(1);
        check("blink_toggle", 32'(bus.blink), 0);
        t0 = n_tick;
        cycles(1200);
        check("sethr_presc_frozen", 32'(n_tick - t0), 0);

        i0 = n_inc_hr;
        m0 = n_inc_min;
        repeat (3) press(4'b0010, p);
        check("sethr_inc_hr", 32'(n_inc_hr - i0), 3);
        check("sethr_inc_min", 32'(n_inc_min - m0), 0);

        press(4'b0001, p);
        check("setmin_set_mode", 32'(bus.set_mode), 2);
        i0 = n_inc_hr;
        m0 = n_inc_min;
        press(4'b0010, p);
        check("setmin_inc_min", 32'(n_inc_min - m0), 1);
        check("setmin_inc_hr", 32'(n_inc_hr - i0), 0);

        // Back to RUN: first tick exactly CLK_HZ cycles after the state change
        tick_log.delete();
        press(4'b0001, p);
        cycles(1005);
        check("run_set_mode", 32'(bus.set_mode), 0);
        check("run_first_tick_count", 32'(tick_log.size()), 1);
        check("run_first_tick_delay", 32'(tick_at(0) - mode_chg_idx), 1000);

        // clr and mode complete together in SET_MIN: clear wins, no mode advance
        press(4'b0001, p);
        press(4'b0001, p);
        check("clr_pre_set_mode", 32'(bus.set_mode), 2);
        r0 = n_rst;
        press(4'b0101, p);
        check("clr_rst_count", 32'(n_rst - r0), 1);
        check("clr_set_mode", 32'(bus.set_mode), 0);
        check("clr_latency", 32'(rst_idx - p), 32'(LAT));
        check("clr_same_cycle", 32'(rst_idx), 32'(mode_chg_idx));
        mc = mode_chg_idx;

        // fmt in RUN: format flips, state and prescaler phase unaffected
        tick_log.delete();
        press(4'b1000, p);
        check("fmt_run_format", 32'(bus.time_format), 0);
        check("fmt_run_set_mode", 32'(bus.set_mode), 0);
        cycles(2100);
        check("fmt_run_tick_phase", 32'((tick_at(0) - mc) % 1000), 0);
        check("fmt_run_tick_period", 32'(tick_at(1) - tick_at(0)), 1000);

        press(4'b0001, p);
        press(4'b1000, p);
        check("fmt_sethr_format", 32'(bus.time_format), 1);
        check("fmt_sethr_set_mode", 32'(bus.set_mode), 1);

        // Hold inc for 1110 cycles in SET_MIN
        press(4'b0001, p);
        check("hold_pre_set_mode", 32'(bus.set_mode), 2);
        inc_log.delete();
        @(negedge CLK);
        p = edges - 1;
        bus.btn_inc = 1'b1;
        cycles(1110);
        bus.btn_inc = 1'b0;
        cycles(20);
`ifdef TIME_CTRL_AUTO_REPEAT_EN
        check("repeat_count", 32'(inc_log.size()), 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("repeat_at_%0d", offs[k]), 32'(inc_at(k) - p), 32'(LAT + offs[k]));
`else
        check("hold_count", 32'(inc_log.size()), 1);
        check("hold_latency", 32'(inc_at(0) - p), 32'(LAT));
`endif

        // Reset mid-debounce discards the pending mode press
        r0 = n_rst;
        i0 = n_inc_hr + n_inc_min;
        @(negedge CLK);
        bus.btn_mode = 1'b1;
        cycles(3);
        rst_n = 1'b0;
        cycles(2);
        check("midrst_set_mode", 32'(bus.set_mode), 0);
        check("midrst_blink", 32'(bus.blink), 0);
        bus.btn_mode = 1'b0;
        rst_n = 1'b1;
        cycles(20);
        check("postrst_set_mode", 32'(bus.set_mode), 0);
        check("postrst_pulses", 32'(n_rst - r0 + n_inc_hr + n_inc_min - i0), 0);

        // Button held through reset release for a full debounce period still registers
        @(negedge CLK);
        bus.btn_mode = 1'b1;
        cycles(3);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(5);
        bus.btn_mode = 1'b0;
        cycles(10);
        check("heldrst_set_mode", 32'(bus.set_mode), 1);

        check("pulse_exclusive", 32'(n_excl), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_time_ctrl.md
# clk_time_ctrl

Front-panel controller for the digital clock datapath. Turns four raw push-buttons into one-cycle command pulses for the seconds/minutes/hours counters. Generates the 1 Hz seconds tick from the 1 kHz system clock and sequences a RUN / SET_HR / SET_MIN time-setting state machine. Sits between the board buttons and the clock counter chain; its outputs drive the counters' enable, increment, clear and 12/24 h select inputs directly.

## Interface
- CLK_HZ, 1000, system clock frequency in Hz; prescaler terminal count is CLK_HZ-1
- DEBOUNCE_MS, 20, input must be stable this many ms before a level change is accepted
- REPEAT_DLY_MS, 500, hold time before the first auto-repeat pulse
- REPEAT_PER_MS, 200, auto-repeat period after the first repeat
- CLK  input  1  system clock, 1 kHz nominal
- rst_n  input  1  reset, asynchronous, active-low
- btn_mode  input  1  raw, asynchronous, active-high; cycles the set mode
- btn_inc  input  1  raw, active-high; increments the selected field
- btn_clr  input  1  raw, active-high; clears the time
- btn_fmt  input  1  raw, active-high; toggles 12/24 h display
- sec_tick  output  1  one-cycle pulse, once per second in RUN
- inc_min  output  1  one-cycle minute-increment pulse, SET_MIN only
- inc_hr  output  1  one-cycle hour-increment pulse, SET_HR only
- rst_counters  output  1  one-cycle synchronous counter clear
- time_format  output  1  1 = 24 h, 0 = 12 h
- set_mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN
- blink  output  1  2 Hz square wave in set states for display flashing; 0 in RUN

## Operation
- Each button path is a 2-FF synchronizer followed by a debouncer. The debouncer counter reloads on every change of the synchronized level. The debounced level updates only after DEBOUNCE_MS*CLK_HZ/1000 consecutive stable cycles.
- A press event is a one-cycle pulse on a debounced rising edge. Release edges generate nothing.
- FSM transitions:
  - RUN -mode-> SET_HR -mode-> SET_MIN -mode-> RUN.
  - clr in any state: go to RUN and pulse rst_counters.
- Event priority per cycle: clr > mode > inc. A lower-priority event in the same cycle is discarded, not deferred. fmt is independent of all other events.
- inc press: one pulse on inc_hr in SET_HR, on inc_min in SET_MIN. Ignored in RUN.
- fmt press toggles time_format in any state.
- Prescaler (width clog2(CLK_HZ)):
  - Counts 0..CLK_HZ-1 only in RUN; sec_tick = 1 when count == CLK_HZ-1, then the count wraps to 0.
  - Held at 0 in SET_HR/SET_MIN. Cleared on rst_counters.
  - After leaving SET_MIN, the first sec_tick comes exactly CLK_HZ cycles later.
- Blink:
  - Toggles every CLK_HZ/4 cycles in set states, starting at 1 on entry to SET_HR.
  - Forced to 0 in RUN. Its own counter is independent of the prescaler.
- sec_tick, inc_min, inc_hr and rst_counters are mutually exclusive in any cycle.

## Timing
- Reset values: state RUN, set_mode 00, time_format 1, blink 0; sec_tick, inc_min, inc_hr and rst_counters all 0; all counters 0; synchronizers and debounced levels 0.
- All outputs are registered.
- Button to output latency: 2 sync cycles + N debounce cycles + 1 edge cycle + 1 output register cycle, where N = DEBOUNCE_MS*CLK_HZ/1000.
- A state change is visible on set_mode in the same cycle as the corresponding pulse output.
- A glitch shorter than N cycles produces no event.
- Asserting rst_n mid-debounce or mid-repeat discards all pending events. No pulse is emitted after release of reset unless a button is still held for a full debounce period.

## Configuration
- TIME_CTRL_AUTO_REPEAT_EN defined:
  - When btn_inc stays debounced-high in a set state, pulses occur at the press, again after REPEAT_DLY_MS, then every REPEAT_PER_MS until release.
  - The repeat counter resets on release or on any state change.
- TIME_CTRL_AUTO_REPEAT_EN undefined: exactly one pulse per press; the repeat counter logic is absent.

## Test plan
- Use CLK_HZ=1000, DEBOUNCE_MS=2 for all scenarios below.
- Reset, then idle 3000 cycles -> sec_tick pulses at cycles 999, 1999, 2999 after reset release; no other output pulses.
- 1-cycle and 1-ms glitches on btn_mode -> set_mode stays 00. A clean 5 ms press -> set_mode 01 with blink 1, and the prescaler is frozen.
- In SET_HR, three separate inc presses -> exactly 3 inc_hr pulses and 0 inc_min. After mode -> set_mode 10; one inc press -> one inc_min pulse. After mode -> RUN, with first sec_tick exactly 1000 cycles later.
- btn_clr and btn_mode debounce-complete in the same cycle while in SET_MIN -> rst_counters pulses once, set_mode 00, no mode advance.
- With TIME_CTRL_AUTO_REPEAT_EN defined, hold inc for 1100 ms in SET_MIN -> inc_min pulses at 0, 500, 700, 900 and 1100 ms after the press. Without the macro -> a single pulse.
- fmt press in RUN and again in SET_HR -> time_format goes 1 -> 0 -> 1, with state and the prescaler unaffected.
